sdram_host_arbiter: RTL
=======================

Name: sdram_host_arbiter

Overview:
- Shares the single host port of the SDRAM controller between two requesters, A (the memory test sequencer) and B (the display/readback path), using fair round-robin arbitration.
- Owns the controller's rd/wr/addr/data strobes for exactly one access per grant.
- Returns the controller's done indication and read data to the granted port only.
- Sits between the requesters and the SDRAM controller inside the sdram_test top level, on the SDRAM clock domain.

Parameters:
ADDR_W, 24, host address width (2 bank + 13 row + 9 column bits)
DATA_W, 16, host data width (matches the SDRAM DQ bus)

Ports:
clk_i  in  1  SDRAM-domain clock; all logic on its rising edge
rst_n_i  in  1  asynchronous active-low reset
a_rd_i  in  1  port A read request; held high until a_done_o
a_wr_i  in  1  port A write request; held high until a_done_o
a_addr_i  in  ADDR_W  port A address; stable while the request is high
a_wdata_i  in  DATA_W  port A write data; stable while a_wr_i is high
a_rdata_o  out  DATA_W  port A registered read data
a_done_o  out  1  port A access-complete pulse
b_rd_i, b_wr_i, b_addr_i, b_wdata_i, b_rdata_o, b_done_o  same as the A-port signals, for port B
ctl_rd_o  out  1  read strobe to the SDRAM controller
ctl_wr_o  out  1  write strobe to the SDRAM controller
ctl_addr_o  out  ADDR_W  address to the SDRAM controller
ctl_wdata_o  out  DATA_W  write data to the SDRAM controller
ctl_rdata_i  in  DATA_W  read data from the SDRAM controller, valid when ctl_done_i is high
ctl_done_i  in  1  controller access-complete, one-cycle pulse
grant_o  out  2  current owner: 00 none, 01 port A, 10 port B

Behaviour:
- Reset (asynchronous, rst_n_i low): state IDLE, last_grant = B (so A wins the first tie), grant_o = 00, ctl_rd_o/ctl_wr_o = 0, ctl_addr_o/ctl_wdata_o = 0, a_rdata_o/b_rdata_o = 0, a_done_o/b_done_o = 0.
- Per-port request: req_x = x_rd_i | x_wr_i.
- Both rd and wr high on the same port is treated as a write.
- States: IDLE, GNT_A, GNT_B.
- IDLE:
  - Only req_a high -> GNT_A.
  - Only req_b high -> GNT_B.
  - Both high -> grant the port not equal to last_grant.
  - Neither high -> stay in IDLE.
  - The decision is registered: a request first seen at cycle n is granted at n+1.
- GNT_x:
  - ctl_rd_o, ctl_wr_o, ctl_addr_o and ctl_wdata_o are a combinational pass-through of port x's inputs.
  - ctl_rd_o is forced to 0 when x_wr_i is high.
  - The other port's request is ignored.
  - Stay in GNT_x until ctl_done_i is high.
  - On the ctl_done_i cycle: last_grant <= x, next state IDLE.
- The single IDLE cycle after every access is mandatory. It lets the requester drop its request after x_done_o, so a stale request is never re-granted.
- Consequence: the minimum spacing between grants is access time + 1 cycle.
- If port x drops its request while in GNT_x before ctl_done_i: strobes fall with it and the arbiter stays in GNT_x until ctl_done_i. The protocol forbids this; the arbiter does not need to recover data.
- x_done_o = ctl_done_i & (state == GNT_x). This is combinational, zero added latency.
- A ctl_done_i pulse while in IDLE is ignored: no done output, no state change.
- Read data:
  - On a ctl_done_i cycle in GNT_x with a read in progress, x_rdata_o <= ctl_rdata_i.
  - x_rdata_o is therefore valid from the cycle after x_done_o and holds until port x's next read completes.
  - Writes and accesses by the other port do not disturb x_rdata_o.
- grant_o reflects the state register (IDLE 00, GNT_A 01, GNT_B 10); it is never 11.
- Outside a grant, ctl_rd_o/ctl_wr_o are 0 and ctl_addr_o/ctl_wdata_o are 0.
- Reset mid-access: state goes to IDLE and the strobes drop immediately. The SDRAM controller shares rst_n_i, so no partial-access cleanup is required.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B.

Test Plan:
- After reset, A read at 0x000123 alone -> grant_o = 01 one cycle later; ctl_rd_o = 1, ctl_addr_o = 0x000123. Controller returns 0xBEEF with ctl_done_i -> a_done_o pulses in the same cycle; a_rdata_o = 0xBEEF next cycle; grant_o = 00 for one cycle.
- A and B both requesting from reset -> grant order A, B, A, B over 4 accesses, with one IDLE cycle between each grant.
- B write 0x5A5A to 0x800001 while A is idle -> ctl_wr_o = 1, ctl_wdata_o = 0x5A5A, ctl_rd_o = 0. b_done_o pulses; a_done_o stays 0; a_rdata_o is unchanged.
- Port A asserts rd and wr together at addr 0x000010 -> ctl_wr_o = 1, ctl_rd_o = 0; a_rdata_o is not updated on done.
- ctl_done_i pulsed while in IDLE -> no done outputs, grant_o stays 00. Then assert rst_n_i low during GNT_B -> grant_o = 00 and ctl_wr_o = 0 immediately; the first grant after release goes to A on a tie.

Source files
------------

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller host port between a test
// sequencer (port A) and a display/readback path (port B), one access per grant.
module sdram_host_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,

  input  logic              a_rd_i,
  input  logic              a_wr_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  output logic              a_done_o,

  input  logic              b_rd_i,
  input  logic              b_wr_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              b_done_o,

  output logic              ctl_rd_o,
  output logic              ctl_wr_o,
  output logic [ADDR_W-1:0] ctl_addr_o,
  output logic [DATA_W-1:0] ctl_wdata_o,
  input  logic [DATA_W-1:0] ctl_rdata_i,
  input  logic              ctl_done_i,

  output logic [1:0]        grant_o
);

  // Encodings double as the grant_o value, so 2'b11 can never appear.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  state_t state;
  logic   last_b;   // 1: B held the most recent grant, so A wins the next tie

  logic req_a;
  logic req_b;
  logic a_read;
  logic b_read;

  assign req_a  = a_rd_i | a_wr_i;
  assign req_b  = b_rd_i | b_wr_i;
  // A simultaneous rd and wr on one port is a write.
  assign a_read = a_rd_i & ~a_wr_i;
  assign b_read = b_rd_i & ~b_wr_i;

  // NOTE: every register here uses <= so all updates read pre-edge values;
  // mixing in = would make the result depend on statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      a_rdata_o <= '0;
      b_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state <= GNT_A;
          end else if (req_b) begin
            state <= GNT_B;
          end
        end
        GNT_A: begin
          if (ctl_done_i) begin
            state  <= IDLE;
            last_b <= 1'b0;
            if (a_read) begin
              a_rdata_o <= ctl_rdata_i;
            end
          end
        end
        GNT_B: begin
          if (ctl_done_i) begin
            state  <= IDLE;
            last_b <= 1'b1;
            if (b_read) begin
              b_rdata_o <= ctl_rdata_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: all outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    ctl_rd_o    = 1'b0;
    ctl_wr_o    = 1'b0;
    ctl_addr_o  = '0;
    ctl_wdata_o = '0;
    case (state)
      GNT_A: begin
        ctl_rd_o    = a_read;
        ctl_wr_o    = a_wr_i;
        ctl_addr_o  = a_addr_i;
        ctl_wdata_o = a_wdata_i;
      end
      GNT_B: begin
        ctl_rd_o    = b_read;
        ctl_wr_o    = b_wr_i;
        ctl_addr_o  = b_addr_i;
        ctl_wdata_o = b_wdata_i;
      end
      default: ;
    endcase
  end

  // Done is steered combinationally; a done pulse in IDLE reaches neither port.
  assign a_done_o = ctl_done_i & (state == GNT_A);
  assign b_done_o = ctl_done_i & (state == GNT_B);
  assign grant_o  = state;

endmodule
